// File: rtl/clk_meas_pkg.sv
// +--------------------------------------------------------------------------+
// | clk_meas_pkg : shared types and defaults for the divided-clock meter.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package clk_meas_pkg;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_MEASURE   = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// +--------------------------------------------------------------------------+
// | sync_edge : multi-flop synchronizer followed by a rising-edge detector.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module sync_edge
    import clk_meas_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic sync_out,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q   <= '0;
            sync_d_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sync_d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~sync_d_q;

endmodule

`default_nettype wire

// File: rtl/clk_div_meas.sv
// +--------------------------------------------------------------------------+
// | clk_div_meas : measures period, high time and 50% duty of a divided clk. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module clk_div_meas
    import clk_meas_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             meas_valid,
    output logic             duty_ok,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic sync_out;
    logic rise;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig_in),
        .sync_out (sync_out),
        .rise     (rise)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] meas_period_q, meas_period_d;
    logic [CNT_W-1:0] meas_high_q, meas_high_d;
    logic             meas_valid_q, meas_valid_d;
    logic             duty_ok_q, duty_ok_d;
    logic             timeout_q, timeout_d;

    // 2*high - period in CNT_W+1 bits: |x| <= 1 means 0, +1 or all-ones.
    logic [CNT_W:0] duty_diff;
    logic           duty_match;

    assign duty_diff  = {high_q, 1'b0} - {1'b0, period_q};
    assign duty_match = (duty_diff == '0) || (duty_diff == (CNT_W+1)'(1)) || (duty_diff == '1);

    always_comb begin
        state_d       = state_q;
        period_d      = period_q;
        high_d        = high_q;
        meas_period_d = meas_period_q;
        meas_high_d   = meas_high_q;
        duty_ok_d     = duty_ok_q;
        meas_valid_d  = 1'b0;
        timeout_d     = 1'b0;

        if (!en) begin
            state_d  = ST_IDLE;
            period_d = '0;
            high_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_WAIT_RISE;
                    period_d = '0;
                    high_d   = '0;
                end
                ST_WAIT_RISE: begin
                    if (rise) begin
                        state_d  = ST_MEASURE;
                        period_d = CNT_ONE;
                        high_d   = CNT_ONE;
                    end
                end
                ST_MEASURE: begin
                    // A rise on the saturation cycle still closes a valid period.
                    if (rise) begin
                        meas_period_d = period_q;
                        meas_high_d   = high_q;
                        duty_ok_d     = duty_match;
                        meas_valid_d  = 1'b1;
                        period_d      = CNT_ONE;
                        high_d        = CNT_ONE;
                    end else if (period_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        state_d   = ST_WAIT_RISE;
                        period_d  = '0;
                        high_d    = '0;
                    end else begin
                        period_d = period_q + CNT_ONE;
                        high_d   = high_q + CNT_W'(sync_out);
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    period_d = '0;
                    high_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            period_q      <= '0;
            high_q        <= '0;
            meas_period_q <= '0;
            meas_high_q   <= '0;
            meas_valid_q  <= 1'b0;
            duty_ok_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_q      <= period_d;
            high_q        <= high_d;
            meas_period_q <= meas_period_d;
            meas_high_q   <= meas_high_d;
            meas_valid_q  <= meas_valid_d;
            duty_ok_q     <= duty_ok_d;
            timeout_q     <= timeout_d;
        end
    end

    assign meas_period = meas_period_q;
    assign meas_high   = meas_high_q;
    assign meas_valid  = meas_valid_q;
    assign duty_ok     = duty_ok_q;
    assign timeout     = timeout_q;

endmodule

`default_nettype wire
